mem_arbiter: RTL
================

# mem_arbiter

Two-port line-request arbiter sitting directly downstream of the instruction and data cache controllers. It multiplexes their 256-bit line read/write requests onto the single DDR line port. It grants one requester at a time with round-robin fairness, holds the DDR handshake until completion, and returns a one-cycle ready pulse with registered read data to the winning cache.

## Interface
- ADDR_WIDTH, 28, line/word address width shared by caches and DDR port
- BLOCK_SIZE, 256, line width in bits

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- d_mem_addr  in  ADDR_WIDTH  D-cache request address (low 3 bits zero)
- d_mem_wr  in  BLOCK_SIZE  D-cache write-back line
- d_mem_rw  in  1  D-cache direction, 1 = write, 0 = read
- d_mem_valid  in  1  D-cache request, held until d_mem_ready
- d_mem_rd  out  BLOCK_SIZE  read line to D-cache
- d_mem_ready  out  1  one-cycle completion pulse to D-cache
- i_mem_addr  in  ADDR_WIDTH  I-cache request address (read-only requester)
- i_mem_valid  in  1  I-cache request, held until i_mem_ready
- i_mem_rd  out  BLOCK_SIZE  read line to I-cache
- i_mem_ready  out  1  one-cycle completion pulse to I-cache
- ddr_addr  out  ADDR_WIDTH  latched request address
- ddr_wr  out  BLOCK_SIZE  latched write line (0 on reads)
- ddr_rw  out  1  latched direction
- ddr_valid  out  1  DDR request, held until ddr_ready
- ddr_rd  in  BLOCK_SIZE  DDR read line, valid with ddr_ready
- ddr_ready  in  1  DDR completion pulse
- arb_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, BUSY, RESP. State register and all latches are reset asynchronously.
- IDLE: sample d_mem_valid and i_mem_valid.
  - One valid: grant it.
  - Both valid: grant the requester not granted last (last_grant flop, reset value = I, so D wins the first tie).
  - On grant: latch addr, direction (I-side forced to read), and wr data (forced to 0 for reads); record the owner; go to BUSY.
  - Neither valid: stay in IDLE.
- BUSY: ddr_valid=1 with latched addr/wr/rw. Requester inputs are ignored; changes to them do not alter the in-flight DDR request.
  - On ddr_ready: capture ddr_rd into the owner's read register (reads only; on writes the rd register keeps its value); update last_grant; go to RESP.
- RESP: owner's ready=1 for exactly this cycle, gated by that requester's current valid. If the owner dropped valid (cache returned to idle / flush skipped a clean line), no ready is issued and the response is discarded. Non-owner ready stays 0. Next state is always IDLE, with no re-grant in RESP.
- The IDLE turnaround cycle exists so the cache can leave its WRITE_BACK/ALLOCATE state before its next request is sampled. This covers back-to-back write-back then allocate from the same cache, and successive flush write-backs.
- d_mem_rd/i_mem_rd are registered and hold the last captured line until the next capture.
- Reset values: state IDLE, ddr_valid 0, ddr_addr 0, ddr_wr 0, ddr_rw 0, d_mem_ready 0, i_mem_ready 0, d_mem_rd 0, i_mem_rd 0, arb_busy 0, last_grant I.
- Reset asserted mid-transaction: everything returns to reset values immediately and the in-flight request is abandoned. The DDR side must tolerate ddr_valid dropping.

## Timing
- Request valid in IDLE at cycle 0 -> ddr_valid high from cycle 1.
- ddr_ready at cycle k≥1 -> owner ready pulse and rd data at k+1 -> IDLE at k+2.
- Minimum request-to-ready latency: 2 cycles. Minimum spacing between grants: 3 cycles.
- ddr_valid drops in the cycle after ddr_ready (RESP). A ddr_ready arriving in IDLE or RESP is ignored.
- Outputs change only on clk edges; the only combinational path is valid gating of the ready pulses.

## Test plan
- Single D read to 0x0000100, DDR returns 0xA5… line after 3 wait cycles -> ddr_valid cycles 1–4, d_mem_ready exactly at cycle 5 with d_mem_rd=0xA5…, i_mem_ready never asserted.
- D write-back to 0x0002008 with line 0x1234… -> ddr_rw=1, ddr_wr=0x1234…, ddr_addr=0x0002008. d_mem_ready pulses once and d_mem_rd is unchanged. An immediately following D read is granted only after the IDLE cycle.
- Simultaneous D and I valid from reset -> D is granted first and I second. With both continuously requesting, grants alternate D,I,D,I over 4 transactions.
- I read completes, then I-cache drops i_mem_valid while in BUSY -> DDR completes, i_mem_ready stays 0, state returns to IDLE, and the next D request is serviced normally.
- rst_n asserted low during BUSY -> ddr_valid, all ready outputs, and arb_busy go to 0 asynchronously. After release, a fresh I read completes with 2-cycle minimum latency.
- Flush sequence of 3 dirty D write-backs with ddr_ready on the first BUSY cycle each -> d_mem_ready pulses at cycles 2, 5, 8 with three distinct ddr_addr values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache line ports and the DDR line port seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the caches/DDR side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int BLOCK_SIZE = 256
);
    logic [ADDR_WIDTH-1:0] d_mem_addr;
    logic [BLOCK_SIZE-1:0] d_mem_wr;
    logic                  d_mem_rw;
    logic                  d_mem_valid;
    logic [BLOCK_SIZE-1:0] d_mem_rd;
    logic                  d_mem_ready;

    logic [ADDR_WIDTH-1:0] i_mem_addr;
    logic                  i_mem_valid;
    logic [BLOCK_SIZE-1:0] i_mem_rd;
    logic                  i_mem_ready;

    logic [ADDR_WIDTH-1:0] ddr_addr;
    logic [BLOCK_SIZE-1:0] ddr_wr;
    logic                  ddr_rw;
    logic                  ddr_valid;
    logic [BLOCK_SIZE-1:0] ddr_rd;
    logic                  ddr_ready;

    // Handshake: a requester raises valid and holds it (with stable payload)
    // until the matching ready pulse; ready is a single-cycle pulse and valid
    // may drop afterwards. The DDR side sees the same rule with ddr_valid/ddr_ready.
    modport slave (
        input  d_mem_addr, d_mem_wr, d_mem_rw, d_mem_valid,
        input  i_mem_addr, i_mem_valid,
        input  ddr_rd, ddr_ready,
        output d_mem_rd, d_mem_ready, i_mem_rd, i_mem_ready,
        output ddr_addr, ddr_wr, ddr_rw, ddr_valid
    );

    modport master (
        output d_mem_addr, d_mem_wr, d_mem_rw, d_mem_valid,
        output i_mem_addr, i_mem_valid,
        output ddr_rd, ddr_ready,
        input  d_mem_rd, d_mem_ready, i_mem_rd, i_mem_ready,
        input  ddr_addr, ddr_wr, ddr_rw, ddr_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter multiplexing I-cache and D-cache line requests onto one
// DDR line port, with registered read lines and a valid-gated ready pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int BLOCK_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arbiter_if.slave bus,
    output logic        arb_busy,
    output logic [1:0]  state_dbg_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BLOCK_SIZE-1:0] wr_q, wr_d;
    logic                  rw_q, rw_d;
    logic [BLOCK_SIZE-1:0] d_rd_q, d_rd_d;
    logic [BLOCK_SIZE-1:0] i_rd_q, i_rd_d;
    logic                  grant_d;
    logic                  grant_i;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_d = bus.d_mem_valid && (!bus.i_mem_valid || (last_q == OWN_I));
        grant_i = bus.i_mem_valid && !grant_d;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rw_d    = rw_q;
        d_rd_d  = d_rd_q;
        i_rd_d  = i_rd_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    addr_d  = bus.d_mem_addr;
                    rw_d    = bus.d_mem_rw;
                    wr_d    = bus.d_mem_rw ? bus.d_mem_wr : '0;
                    state_d = BUSY;
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    addr_d  = bus.i_mem_addr;
                    rw_d    = 1'b0;
                    wr_d    = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.ddr_ready) begin
                    if (!rw_q) begin
                        if (owner_q == OWN_D) d_rd_d = bus.ddr_rd;
                        else                  i_rd_d = bus.ddr_rd;
                    end
                    last_d  = owner_q;
                    state_d = RESP;
                end
            end
            // The return to IDLE gives the cache a cycle to leave its
            // write-back/allocate state before its next request is sampled.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            addr_q  <= '0;
            wr_q    <= '0;
            rw_q    <= 1'b0;
            d_rd_q  <= '0;
            i_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rw_q    <= rw_d;
            d_rd_q  <= d_rd_d;
            i_rd_q  <= i_rd_d;
        end
    end

    assign bus.ddr_valid = (state_q == BUSY);
    assign bus.ddr_addr  = addr_q;
    assign bus.ddr_wr    = wr_q;
    assign bus.ddr_rw    = rw_q;
    assign bus.d_mem_rd  = d_rd_q;
    assign bus.i_mem_rd  = i_rd_q;
    // A requester that withdrew its valid gets no ready; the response is dropped.
    assign bus.d_mem_ready = (state_q == RESP) && (owner_q == OWN_D) && bus.d_mem_valid;
    assign bus.i_mem_ready = (state_q == RESP) && (owner_q == OWN_I) && bus.i_mem_valid;
    assign arb_busy      = (state_q != IDLE);
    assign state_dbg_o   = state_q;

endmodule
